// File: rtl/buf_sobel_to_nms.sv
// rtl/buf_sobel_to_nms.sv - two-line buffered 3x3 non-maximum suppression after Sobel
module buf_sobel_to_nms #(
    parameter int WIDTH  = 506,
    parameter int HEIGHT = 506,
    parameter int MAG_W  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write,
    input  logic [MAG_W-1:0] in_mag,
    input  logic [1:0]       in_angle,
    output logic [MAG_W-1:0] out_mag,
    output logic             ready,
    output logic             frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int LW = MAG_W + 2;

    // Line RAMs hold {angle, magnitude}; line1 = row r-1, line2 = row r-2.
    logic [LW-1:0] line1 [WIDTH];
    logic [LW-1:0] line2 [WIDTH];

    logic [CW-1:0]    col_q, col_d;
    logic [RW-1:0]    row_q, row_d;
    // Column 1 is the older (west of centre) column, column 2 the centre column.
    // The east column is never stored: it is the line-buffer read plus in_mag
    // at the accepting edge, which is exactly when the result is computed.
    logic [MAG_W-1:0] c1t_q, c1m_q, c1b_q, c1t_d, c1m_d, c1b_d;
    logic [MAG_W-1:0] c2t_q, c2m_q, c2b_q, c2t_d, c2m_d, c2b_d;
    logic [1:0]       ang_q, ang_d;
    logic [MAG_W-1:0] out_mag_q, out_mag_d;
    logic             ready_q, ready_d;
    logic             frame_done_q, frame_done_d;

    logic [LW-1:0]    rd1, rd2;
    logic [MAG_W-1:0] e_top, e_mid, e_bot, n1, n2, nms;
    logic             col_last, row_last, emit;

    assign rd1   = line1[col_q];
    assign rd2   = line2[col_q];
    assign e_top = rd2[MAG_W-1:0];
    assign e_mid = rd1[MAG_W-1:0];
    assign e_bot = in_mag;

    // Pick the neighbour pair along the centre's gradient direction and suppress.
    always_comb begin
        n1 = '0;
        n2 = '0;
        case (ang_q)
            2'd0: begin n1 = c1m_q; n2 = e_mid; end   // W, E
            2'd1: begin n1 = e_top; n2 = c1b_q; end   // NE, SW
            2'd2: begin n1 = c2t_q; n2 = c2b_q; end   // N, S
            default: begin n1 = c1t_q; n2 = e_bot; end // NW, SE
        endcase
        nms = (c2m_q >= n1 && c2m_q >= n2) ? c2m_q : '0;
    end

    // Raster counters, window shift and output registration on accepted pixels.
    always_comb begin
        col_last     = (col_q == CW'(WIDTH - 1));
        row_last     = (row_q == RW'(HEIGHT - 1));
        emit         = write && (row_q >= RW'(2)) && (col_q >= CW'(2));
        col_d        = col_q;
        row_d        = row_q;
        c1t_d        = c1t_q;
        c1m_d        = c1m_q;
        c1b_d        = c1b_q;
        c2t_d        = c2t_q;
        c2m_d        = c2m_q;
        c2b_d        = c2b_q;
        ang_d        = ang_q;
        if (write) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) begin
                row_d = row_last ? '0 : row_q + 1'b1;
            end
            c1t_d = c2t_q;
            c1m_d = c2m_q;
            c1b_d = c2b_q;
            c2t_d = e_top;
            c2m_d = e_mid;
            c2b_d = e_bot;
            ang_d = rd1[LW-1:MAG_W];
        end
        ready_d      = emit;
        frame_done_d = emit && col_last && row_last;
        out_mag_d    = emit ? nms : out_mag_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            c1t_q        <= '0;
            c1m_q        <= '0;
            c1b_q        <= '0;
            c2t_q        <= '0;
            c2m_q        <= '0;
            c2b_q        <= '0;
            ang_q        <= '0;
            out_mag_q    <= '0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            c1t_q        <= c1t_d;
            c1m_q        <= c1m_d;
            c1b_q        <= c1b_d;
            c2t_q        <= c2t_d;
            c2m_q        <= c2m_d;
            c2b_q        <= c2b_d;
            ang_q        <= ang_d;
            out_mag_q    <= out_mag_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line RAM update: new pixel into line1, displaced line1 entry down into line2.
    always_ff @(posedge clk) begin
        if (write) begin
            line1[col_q] <= {in_angle, in_mag};
            line2[col_q] <= rd1;
        end
    end

    assign out_mag    = out_mag_q;
    assign ready      = ready_q;
    assign frame_done = frame_done_q;
endmodule
